// File: rtl/herm_pkg.sv
// Shared constants and state encoding for the Hermitian-remover datapath.
// Also used by the remover and demapper blocks.
package herm_pkg;

    localparam int FFT_POINT = 64;
    localparam int SYM_NUM   = 8;
    localparam int ACTIVE_SC = 28;
    localparam int IN_LEN    = FFT_POINT * SYM_NUM;
    localparam int OUT_LEN   = ACTIVE_SC * SYM_NUM;
    localparam int IN_CNT_W  = $clog2(IN_LEN);
    localparam int OUT_CNT_W = $clog2(OUT_LEN);
    localparam int PTR_W     = 9;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_RMV = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_FLUSH    = 3'd5,
        ST_REARM    = 3'd6
    } herm_state_e;

endpackage

// File: rtl/herm_rmv_ctrl_if.sv
// FFT input stream, remover side-band and downstream stream of the burst sequencer.
// master = sequencer view, slave = surrounding logic view.
interface herm_rmv_ctrl_if
    import herm_pkg::*;
#(
    parameter int DATA_W = 16
) ();
    logic              fft_valid;
    logic              fft_ready;
    logic [DATA_W-1:0] fft_data;
    logic [DATA_W-1:0] rmv_din;
    logic              rmv_wren;
    logic              rmv_tx_done;
    logic [PTR_W-1:0]  rmv_read_ptr;
    logic              rmv_out_full;
    logic [DATA_W-1:0] rmv_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              err_timeout;

    modport master (
        input  fft_valid, fft_data, rmv_out_full, rmv_dout, m_ready,
        output fft_ready, rmv_din, rmv_wren, rmv_tx_done, rmv_read_ptr,
               m_data, m_valid, m_last, busy, err_timeout
    );

    modport slave (
        output fft_valid, fft_data, rmv_out_full, rmv_dout, m_ready,
        input  fft_ready, rmv_din, rmv_wren, rmv_tx_done, rmv_read_ptr,
               m_data, m_valid, m_last, busy, err_timeout
    );
endinterface

// File: rtl/herm_skid_fifo.sv
// Small skid FIFO with occupancy count, head presented combinationally.
// Latency: a pushed word is visible at dout the cycle after the push.
// Backpressure: none internally; the writer must never push when full.
module herm_skid_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/herm_rmv_ctrl.sv
// Burst sequencer: loads one burst into the Hermitian remover, drains its kept bins downstream, re-arms it.
// Latency: rmv_din/rmv_wren one cycle after each FFT handshake; read data enters the skid FIFO RD_LAT cycles after its read_ptr.
// Backpressure: reads issue only with FIFO credit, so m_ready stalls never drop or duplicate samples; fft_ready low outside LOAD.
module herm_rmv_ctrl
    import herm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    herm_rmv_ctrl_if.master bus
);
    localparam int FIFO_DEPTH = RD_LAT + 1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W     = $clog2(TIMEOUT);
    // Token positions younger than RD_LAT-1 mean read_ptr has not yet been held RD_LAT cycles.
    localparam logic [RD_LAT-1:0] RECENT = {RD_LAT{1'b1}} >> 1;

    herm_state_e          state, state_n;
    logic [IN_CNT_W-1:0]  in_cnt;
    logic [OUT_CNT_W-1:0] rd_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [RD_LAT-1:0]    tok;
    logic [RD_LAT-1:0]    tok_last;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [DATA_W:0]      fifo_head;
    logic                 fifo_empty;
    logic                 fft_hs, in_last, rd_last, tmo, credit_ok, issue, pop;

    assign fft_hs    = bus.fft_valid && bus.fft_ready;
    assign in_last   = (in_cnt == IN_CNT_W'(IN_LEN - 1));
    assign rd_last   = (rd_cnt == OUT_CNT_W'(OUT_LEN - 1));
    assign tmo       = (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign credit_ok = (int'(fifo_cnt) + $countones(tok)) < FIFO_DEPTH;
    assign issue     = (state == ST_DRAIN) && ((tok & RECENT) == '0) && credit_ok;
    assign pop       = !fifo_empty && bus.m_ready;

    always_comb begin
        state_n = state;
        case (state)
            ST_INIT:     state_n = ST_IDLE;
            ST_IDLE:     if (bus.fft_valid) state_n = ST_LOAD;
            ST_LOAD:     if (fft_hs && in_last) state_n = ST_WAIT_RMV;
            ST_WAIT_RMV: begin
                if (bus.rmv_out_full) state_n = ST_DRAIN;
                else if (tmo)         state_n = ST_REARM;
            end
            ST_DRAIN:    if (issue && rd_last) state_n = ST_FLUSH;
            ST_FLUSH:    if ((tok == '0) && fifo_empty) state_n = ST_REARM;
            ST_REARM:    state_n = ST_IDLE;
            default:     state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_INIT;
            in_cnt           <= '0;
            rd_cnt           <= '0;
            wait_cnt         <= '0;
            tok              <= '0;
            tok_last         <= '0;
            bus.rmv_din      <= '0;
            bus.rmv_wren     <= 1'b0;
            bus.rmv_tx_done  <= 1'b0;
            bus.rmv_read_ptr <= '0;
            bus.err_timeout  <= 1'b0;
        end else begin
            state           <= state_n;
            bus.rmv_wren    <= fft_hs;
            bus.rmv_tx_done <= (state == ST_INIT) || (state == ST_REARM);
            wait_cnt        <= (state == ST_WAIT_RMV) ? wait_cnt + 1'b1 : '0;
            tok             <= (tok << 1) | RD_LAT'(issue);
            tok_last        <= (tok_last << 1) | RD_LAT'(issue && rd_last);
            if (fft_hs) begin
                bus.rmv_din <= bus.fft_data;
                in_cnt      <= in_last ? '0 : in_cnt + 1'b1;
            end
            if ((state == ST_WAIT_RMV) && !bus.rmv_out_full && tmo) begin
                bus.err_timeout <= 1'b1;
            end
            if (issue) begin
                bus.rmv_read_ptr <= PTR_W'(rd_cnt);
                rd_cnt           <= rd_last ? '0 : rd_cnt + 1'b1;
            end
        end
    end

    herm_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tok[RD_LAT-1]),
        .din   ({tok_last[RD_LAT-1], bus.rmv_dout}),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.fft_ready = (state == ST_LOAD);
    assign bus.busy      = (state != ST_IDLE) && (state != ST_INIT);
    assign bus.m_valid   = !fifo_empty;
    assign bus.m_data    = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign bus.m_last    = !fifo_empty && fifo_head[DATA_W];

endmodule

// File: tb/tb_herm_rmv_ctrl.sv
// Bench for herm_rmv_ctrl: behavioural remover, scoreboard queue of expected kept bins, negedge monitor.
module tb_herm_rmv_ctrl;
    import herm_pkg::*;

    localparam int DATA_W  = 16;
    localparam int RD_LAT  = 3;
    localparam int TIMEOUT = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    herm_rmv_ctrl_if #(.DATA_W(DATA_W)) bus ();

    herm_rmv_ctrl #(.DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    beat_t exp_q[$];
    int n_pass = 0;
    int n_fail = 0;
    int beats = 0, wren_tot = 0, tx_tot = 0, last_tot = 0, ptr_hold = RD_LAT;
    int ready_mode = 0;
    bit never_full = 1'b0;

    function automatic void check(input string name, input longint act, input longint exp);
        if (act == exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [DATA_W-1:0] pat(input int b, input int i);
        return DATA_W'(b * 4096 + i);
    endfunction

    // Kept bins are 1..ACTIVE_SC of each symbol.
    function automatic int act_idx(input int k);
        return (k / ACTIVE_SC) * FFT_POINT + 1 + (k % ACTIVE_SC);
    endfunction

    // Behavioural remover: out_full 480 cycles after the 512th write, RD_LAT-cycle read path.
    logic [DATA_W-1:0] rin [IN_LEN];
    int wr_n = 0, full_cnt = 0;
    logic [PTR_W-1:0] p1 = '0, p2 = '0;

    always @(posedge clk) begin
        if (rst || bus.rmv_tx_done) begin
            wr_n             <= 0;
            full_cnt         <= 0;
            bus.rmv_out_full <= 1'b0;
        end else begin
            if (bus.rmv_wren) begin
                if (wr_n < IN_LEN) rin[wr_n] <= bus.rmv_din;
                wr_n <= wr_n + 1;
            end
            if (wr_n == IN_LEN && !never_full && !bus.rmv_out_full) begin
                full_cnt <= full_cnt + 1;
                if (full_cnt == 479) bus.rmv_out_full <= 1'b1;
            end
        end
        p1 <= bus.rmv_read_ptr;
        p2 <= p1;
    end
    assign bus.rmv_dout = rin[act_idx(int'(p2))];

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
        end
    end

    // Monitor: pops the scoreboard on each accepted beat, checks stalls and read_ptr hold.
    logic [PTR_W-1:0] ptr_prev = '0;
    always @(negedge clk) begin
        if (rst) begin
            ptr_hold = RD_LAT;
        end else begin
            if (bus.rmv_wren)    wren_tot++;
            if (bus.rmv_tx_done) tx_tot++;
            check("fifo_within_depth", longint'(dut.fifo_cnt <= (RD_LAT + 1)), 1);
            if (bus.rmv_read_ptr != ptr_prev) begin
                check("read_ptr_hold", longint'(ptr_hold >= RD_LAT), 1);
                ptr_hold = 1;
            end else ptr_hold++;
            if (bus.m_valid) begin
                if (exp_q.size() == 0) check("beat_without_expectation", 1, 0);
                else if (bus.m_ready) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("m_data", bus.m_data, b.d);
                    check("m_last", bus.m_last, b.l);
                    beats++;
                    if (bus.m_last) last_tot++;
                end else begin
                    check("stall_m_data", bus.m_data, exp_q[0].d);
                end
            end
        end
        ptr_prev = bus.rmv_read_ptr;
    end

    task automatic push_expected(input int b);
        for (int k = 0; k < OUT_LEN; k++) begin
            beat_t e;
            e.d = pat(b, act_idx(k));
            e.l = (k == OUT_LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called #1 after a posedge; returns at the negedge of the first WAIT_RMV cycle.
    task automatic send_burst(input int b, input bit rnd);
        int idx = 0;
        int g = 0;
        bit hs;
        while (idx < IN_LEN && g < 20000) begin
            bus.fft_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.fft_data  = pat(b, idx);
            @(negedge clk);
            hs = bus.fft_valid && bus.fft_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            g++;
        end
        bus.fft_valid = 1'b0;
        check("samples_accepted", idx, IN_LEN);
        @(negedge clk);
        check("fft_ready_drop", bus.fft_ready, 0);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!bus.rmv_tx_done && g < 6000) begin
            @(negedge clk);
            g++;
        end
        check({"tx_done_seen_", tag}, longint'(g < 6000), 1);
        check({"busy_low_", tag}, bus.busy, 0);
        check({"all_beats_out_", tag}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_fft_ready"}, bus.fft_ready, 0);
        check({tag, "_wren"}, bus.rmv_wren, 0);
        check({tag, "_tx_done"}, bus.rmv_tx_done, 0);
        check({tag, "_read_ptr"}, bus.rmv_read_ptr, 0);
        check({tag, "_din"}, bus.rmv_din, 0);
        check({tag, "_m_valid"}, bus.m_valid, 0);
        check({tag, "_m_data"}, bus.m_data, 0);
        check({tag, "_m_last"}, bus.m_last, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_err"}, bus.err_timeout, 0);
    endtask

    task automatic check_totals(input string tag, input int wr, input int tx, input int lst);
        check({tag, "_wren_total"}, wren_tot, wr);
        check({tag, "_tx_total"}, tx_tot, tx);
        check({tag, "_last_total"}, last_tot, lst);
    endtask

    initial begin
        int n, g, base;
        bus.fft_valid = 1'b0;
        bus.fft_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("init_tx_done", bus.rmv_tx_done, 1);
        @(negedge clk);
        check("init_tx_one_cycle", bus.rmv_tx_done, 0);
        @(posedge clk); #1;

        // 1: continuous input, always ready
        push_expected(0); send_burst(0, 1'b0); wait_done("b0");
        check_totals("b0", 512, 2, 1);
        check("b0_beats", beats, 224);

        // 2: 50% input valid
        push_expected(1); send_burst(1, 1'b1); wait_done("b1");
        check_totals("b1", 1024, 3, 2);

        // 3: 30% downstream ready
        ready_mode = 1;
        push_expected(2); send_burst(2, 1'b0); wait_done("b2");
        ready_mode = 0;
        check_totals("b2", 1536, 4, 3);

        // 4: remover never fills -> timeout, then a normal burst
        never_full = 1'b1;
        base = beats;
        send_burst(3, 1'b0);
        n = 1;
        @(negedge clk);
        while (!bus.err_timeout && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("timeout_wait_cycles", n, TIMEOUT);
        wait_done("b3");
        never_full = 1'b0;
        check("timeout_no_beats", beats - base, 0);
        check_totals("b3", 2048, 5, 3);
        push_expected(4); send_burst(4, 1'b0); wait_done("b4");
        check("err_sticky", bus.err_timeout, 1);
        check_totals("b4", 2560, 6, 4);

        // 5: reset at drain beat 100
        base = beats;
        push_expected(5); send_burst(5, 1'b0);
        g = 0;
        while (beats < base + 100 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        check("reached_beat_100", beats - base, 100);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_zero("midreset");
        @(negedge clk);
        check("midreset_tx_done", bus.rmv_tx_done, 1);
        @(posedge clk); #1;
        push_expected(6); send_burst(6, 1'b0); wait_done("b6");
        check_totals("b6", 3584, 8, 5);

        // 6: three back-to-back bursts
        base = beats;
        for (int b = 7; b < 10; b++) begin
            push_expected(b);
            send_burst(b, 1'b0);
            wait_done($sformatf("b%0d", b));
        end
        check("b2b_beats", beats - base, 672);
        check_totals("b2b", 5120, 11, 8);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
